pc_gen: RTL and testbench



---
 rtl/rv_pkg.sv | 21 ++
 rtl/pc_gen.sv | 95 +++++++++
 tb/tb_pc_gen.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared front-end definitions: datapath width, instruction size, PC generator
// state encoding and the redirect-target legality check.
package rv_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } pc_gen_state_t;

  // A target is unusable when it is not word aligned or lies past the end of imem.
  function automatic logic is_bad_target(input logic [XLEN-1:0] addr,
                                         input logic [XLEN-1:0] mem_bytes);
    return (addr[1:0] != 2'b00) || (addr >= mem_bytes);
  endfunction

endpackage

// File: rtl/pc_gen.sv
// Program-counter stage feeding a 1-cycle synchronous instruction memory.
// if_pc/if_valid are registered on the same edge that imem captures mem[pc].
module pc_gen
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 16
) (
  input  logic                clk,
  input  logic                rst,
  output logic [XLEN-1:0]     pc,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_target,
  input  logic                halt_req,
  output logic                if_valid,
  output logic [XLEN-1:0]     if_pc,
  output logic                halted,
  output logic                fault,
  output logic [XLEN-1:0]     fetch_count,
  output pc_gen_state_t       state_dbg
);

  // Handshake to decode: an instruction transfers on a cycle with if_valid=1,
  // stall=0 and redirect_valid=0; while stall=1 pc, if_pc and if_valid are held.

  localparam logic [XLEN-1:0] PC_MASK = XLEN'(IMEM_BYTES - 1);
  localparam logic [XLEN-1:0] MEM_TOP = XLEN'(IMEM_BYTES);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(INSTR_BYTES);

  pc_gen_state_t   state, state_next;
  logic [XLEN-1:0] pc_inc, pc_d, if_pc_d;
  logic            if_valid_d, target_bad, accept;

  assign pc_inc     = (pc + PC_STEP) & PC_MASK;
  assign target_bad = is_bad_target(redirect_target, MEM_TOP);
  assign accept     = if_valid && !stall && !redirect_valid;

  always_comb begin
    state_next = state;
    pc_d       = pc;
    if_pc_d    = pc;
    if_valid_d = 1'b0;
    case (state)
      BOOT: state_next = RUN;
      RUN: begin
        if (redirect_valid && target_bad) begin
          state_next = FAULT;
        end else if (redirect_valid) begin
          pc_d = redirect_target;
        end else if (halt_req) begin
          state_next = HALT;
        end else if (stall) begin
          if_pc_d    = if_pc;
          if_valid_d = if_valid;
        end else begin
          pc_d       = pc_inc;
          if_valid_d = 1'b1;
        end
      end
      HALT: begin
        if (redirect_valid && target_bad) begin
          state_next = FAULT;
        end else if (redirect_valid) begin
          state_next = RUN;
          pc_d       = redirect_target;
        end
      end
      FAULT: state_next = FAULT;
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      if_pc       <= RESET_PC;
      if_valid    <= 1'b0;
      fetch_count <= '0;
    end else begin
      state    <= state_next;
      pc       <= pc_d;
      if_pc    <= if_pc_d;
      if_valid <= if_valid_d;
      if (accept) fetch_count <= fetch_count + 1'b1;
    end
  end

  // FAULT is only left through rst, so deriving fault from state keeps it sticky.
  assign halted    = (state == HALT);
  assign fault     = (state == FAULT);
  assign state_dbg = state;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen with IMEM_BYTES=16, RESET_PC=0.
module tb_pc_gen;
  import rv_pkg::*;

  logic          clk, rst, stall, redirect_valid, halt_req;
  logic [31:0]   redirect_target;
  logic [31:0]   pc, if_pc, fetch_count;
  logic          if_valid, halted, fault;
  pc_gen_state_t state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  pc_gen #(.RESET_PC(32'h0), .IMEM_BYTES(16)) dut (
    .clk(clk), .rst(rst), .pc(pc), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .halt_req(halt_req), .if_valid(if_valid), .if_pc(if_pc),
    .halted(halted), .fault(fault), .fetch_count(fetch_count),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0; halt_req = 1'b0;
  endtask

  // Leaves the bench 1ns after an edge with the DUT in its BOOT cycle.
  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] e_pc[7]   = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd0, 32'd4, 32'd8};
    logic [31:0] e_ifpc[7] = '{32'd0, 32'd0, 32'd4, 32'd8, 32'd12, 32'd0, 32'd4};
    logic        e_iv[7]   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [31:0] e_cnt[7]  = '{32'd0, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    apply_reset();
    n_tests++;
    if ({pc, if_pc, if_valid, halted, fault, fetch_count} !== {32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_vals: pc=%0h if_pc=%0h iv=%0b halted=%0b fault=%0b cnt=%0d, need all zero",
               pc, if_pc, if_valid, halted, fault, fetch_count);
    end
    n_tests++;
    if (state_dbg !== BOOT) begin
      n_fail++; $display("FAIL reset_state: got %0d need %0d", state_dbg, BOOT);
    end
    for (int i = 0; i < 7; i++) begin
      step();
      n_tests++;
      if ({pc, if_pc, if_valid, fetch_count} !== {e_pc[i], e_ifpc[i], e_iv[i], e_cnt[i]}) begin
        n_fail++;
        $display("FAIL seq[%0d]: pc=%0h if_pc=%0h iv=%0b cnt=%0d, need pc=%0h if_pc=%0h iv=%0b cnt=%0d",
                 i, pc, if_pc, if_valid, fetch_count, e_pc[i], e_ifpc[i], e_iv[i], e_cnt[i]);
      end
    end
  endtask

  task automatic test_stall();
    apply_reset();
    repeat (3) step();  // pc=8, if_pc=4, cnt=1
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if ({pc, if_pc, if_valid, fetch_count} !== {32'd8, 32'd4, 1'b1, 32'd1}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: pc=%0h if_pc=%0h iv=%0b cnt=%0d, need 8 4 1 1",
                 i, pc, if_pc, if_valid, fetch_count);
      end
    end
    stall = 1'b0;
    step();
    n_tests++;
    if ({pc, if_pc, if_valid, fetch_count} !== {32'd12, 32'd8, 1'b1, 32'd2}) begin
      n_fail++;
      $display("FAIL stall_release: pc=%0h if_pc=%0h iv=%0b cnt=%0d, need c 8 1 2",
               pc, if_pc, if_valid, fetch_count);
    end
  endtask

  task automatic test_redirect_stall();
    apply_reset();
    repeat (2) step();  // pc=4, if_pc=0 valid
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h8;
    step();
    clear_inputs();
    n_tests++;
    if ({pc, if_valid, fetch_count} !== {32'd8, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL redir_squash: pc=%0h iv=%0b cnt=%0d, need 8 0 0", pc, if_valid, fetch_count);
    end
    step();
    n_tests++;
    if ({pc, if_pc, if_valid, fetch_count} !== {32'd12, 32'd8, 1'b1, 32'd0}) begin
      n_fail++;
      $display("FAIL redir_target: pc=%0h if_pc=%0h iv=%0b cnt=%0d, need c 8 1 0",
               pc, if_pc, if_valid, fetch_count);
    end
    step();
    n_tests++;
    if ({pc, if_pc, fetch_count} !== {32'd0, 32'd12, 32'd1}) begin
      n_fail++;
      $display("FAIL redir_wrap: pc=%0h if_pc=%0h cnt=%0d, need 0 c 1", pc, if_pc, fetch_count);
    end
  endtask

  task automatic test_redirect_first_run();
    apply_reset();
    step();  // first RUN cycle, pc=0
    redirect_valid = 1'b1; redirect_target = 32'hC;
    step();
    clear_inputs();
    n_tests++;
    if ({pc, if_valid, state_dbg} !== {32'd12, 1'b0, RUN}) begin
      n_fail++;
      $display("FAIL first_run_redir: pc=%0h iv=%0b st=%0d, need c 0 %0d", pc, if_valid, state_dbg, RUN);
    end
    step();
    n_tests++;
    if ({pc, if_pc, if_valid} !== {32'd0, 32'd12, 1'b1}) begin
      n_fail++;
      $display("FAIL first_run_follow: pc=%0h if_pc=%0h iv=%0b, need 0 c 1", pc, if_pc, if_valid);
    end
  endtask

  task automatic test_fault();
    logic [31:0] tgt[2]   = '{32'h6, 32'h10};
    logic [31:0] at_pc[2] = '{32'h4, 32'h8};
    for (int k = 0; k < 2; k++) begin
      apply_reset();
      repeat (k + 2) step();
      redirect_valid = 1'b1; redirect_target = tgt[k];
      step();
      clear_inputs();
      n_tests++;
      if ({fault, if_valid, pc, halted} !== {1'b1, 1'b0, at_pc[k], 1'b0}) begin
        n_fail++;
        $display("FAIL fault_enter[%0h]: fault=%0b iv=%0b pc=%0h halted=%0b, need 1 0 %0h 0",
                 tgt[k], fault, if_valid, pc, halted, at_pc[k]);
      end
      // A good redirect and a halt request must not leave FAULT.
      redirect_valid = 1'b1; redirect_target = 32'h0; halt_req = 1'b1;
      repeat (3) step();
      clear_inputs();
      step();
      n_tests++;
      if ({fault, if_valid, pc, state_dbg} !== {1'b1, 1'b0, at_pc[k], FAULT}) begin
        n_fail++;
        $display("FAIL fault_sticky[%0h]: fault=%0b iv=%0b pc=%0h st=%0d, need 1 0 %0h %0d",
                 tgt[k], fault, if_valid, pc, state_dbg, at_pc[k], FAULT);
      end
      apply_reset();
      n_tests++;
      if ({fault, pc} !== {1'b0, 32'd0}) begin
        n_fail++;
        $display("FAIL fault_clear[%0h]: fault=%0b pc=%0h, need 0 0", tgt[k], fault, pc);
      end
    end
  endtask

  task automatic test_halt();
    apply_reset();
    repeat (3) step();  // pc=8, cnt=1, if_valid=1
    halt_req = 1'b1;
    step();
    n_tests++;
    if ({halted, if_valid, pc, fetch_count} !== {1'b1, 1'b0, 32'd8, 32'd2}) begin
      n_fail++;
      $display("FAIL halt_enter: halted=%0b iv=%0b pc=%0h cnt=%0d, need 1 0 8 2",
               halted, if_valid, pc, fetch_count);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      n_tests++;
      if ({halted, if_valid, pc, fetch_count} !== {1'b1, 1'b0, 32'd8, 32'd2}) begin
        n_fail++;
        $display("FAIL halt_hold[%0d]: halted=%0b iv=%0b pc=%0h cnt=%0d, need 1 0 8 2",
                 i, halted, if_valid, pc, fetch_count);
      end
    end
    halt_req = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h4;
    step();
    clear_inputs();
    n_tests++;
    if ({halted, pc, if_valid} !== {1'b0, 32'd4, 1'b0}) begin
      n_fail++;
      $display("FAIL halt_exit: halted=%0b pc=%0h iv=%0b, need 0 4 0", halted, pc, if_valid);
    end
    step();
    n_tests++;
    if ({if_pc, if_valid, pc} !== {32'd4, 1'b1, 32'd8}) begin
      n_fail++;
      $display("FAIL halt_resume: if_pc=%0h iv=%0b pc=%0h, need 4 1 8", if_pc, if_valid, pc);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    repeat (4) step();  // pc=12
    #2;
    rst = 1'b1;
    #1;  // still well before the next rising edge
    n_tests++;
    if ({pc, if_pc, if_valid, fetch_count, halted, fault} !== {32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_rst: pc=%0h if_pc=%0h iv=%0b cnt=%0d halted=%0b fault=%0b, need all zero",
               pc, if_pc, if_valid, fetch_count, halted, fault);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_tests++;
    if (state_dbg !== BOOT) begin
      n_fail++; $display("FAIL async_boot: st=%0d need %0d", state_dbg, BOOT);
    end
    repeat (2) step();
    n_tests++;
    if ({pc, if_pc, if_valid} !== {32'd4, 32'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL async_resume: pc=%0h if_pc=%0h iv=%0b, need 4 0 1", pc, if_pc, if_valid);
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_stall();
    test_redirect_stall();
    test_redirect_first_run();
    test_fault();
    test_halt();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
